// File: rtl/banner_fader_if.sv
// ROM read bus and overlay pixel output of banner_fader.
// master: the fader (drives ROM address/select and overlay pixel).
// slave : ROM + downstream mixer (returns ROM data, consumes pixel).
interface banner_fader_if #(
  parameter int ADDR_W = 13,
  parameter int SEL_W  = 2
);
  logic [ADDR_W-1:0] o_rom_addr;
  logic [SEL_W-1:0]  o_rom_sel;
  logic [11:0]       i_rom_data;
  logic [3:0]        o_red;
  logic [3:0]        o_green;
  logic [3:0]        o_blue;
  logic              o_pix_valid;

  modport master (
    output o_rom_addr, o_rom_sel, o_red, o_green, o_blue, o_pix_valid,
    input  i_rom_data
  );

  modport slave (
    input  o_rom_addr, o_rom_sel, o_red, o_green, o_blue, o_pix_valid,
    output i_rom_data
  );
endinterface

// File: rtl/banner_fader.sv
// banner_fader: places one of NUM_IMAGES banner bitmaps at a frame-latched
// position and fades it in/out, one brightness step every FRAMES_PER_STEP
// frames.
// Pipeline: coordinates -> (edge 1) ROM address/select -> (edge 2) ROM data
// -> (edge 3) scaled overlay pixel. Box, display-enable and level follow
// the address so they line up with the returned ROM word.
// Optional build macro BANNER_FADER_BLINK_EN: blinks the banner in SHOW
// (16 frames on, 16 off). Undefined: SHOW is steady.
//
// state    | meaning
// IDLE     | banner hidden, level 0
// FADE_IN  | level rising one step at a time
// SHOW     | fully visible, level 15
// FADE_OUT | level falling; at 0 restart with new image or go idle
module banner_fader #(
  parameter int SCREEN_WIDTH    = 800,
  parameter int SCREEN_HEIGHT   = 600,
  parameter int BANNER_W        = 100,
  parameter int BANNER_H        = 50,
  parameter int NUM_IMAGES      = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_show,
  input  logic [$clog2(NUM_IMAGES)-1:0] i_banner_num,
  input  logic [10:0]                   i_pos_x,
  input  logic [9:0]                    i_pos_y,
  input  logic                          i_frame_start,
  input  logic                          i_disp_enbl,
  input  logic [10:0]                   i_h_coord,
  input  logic [9:0]                    i_v_coord,
  banner_fader_if.master                bf,
  output logic                          o_busy
);

  localparam int SEL_W  = $clog2(NUM_IMAGES);
  localparam int ADDR_W = $clog2(BANNER_W * BANNER_H);
  localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {IDLE, FADE_IN, SHOW, FADE_OUT} state_t;

  state_t             r_state, w_state_n;
  logic [3:0]         r_level, w_level_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [SEL_W-1:0]   r_num, w_num_n;
  logic [10:0]        r_pos_x;
  logic [9:0]         r_pos_y;
  logic               w_step;
  logic [3:0]         w_level_eff;

  logic [11:0]        w_rel_x, w_rel_y;
  logic               w_on_screen, w_in_box;
  logic [ADDR_W-1:0]  w_lin, w_addr;

  logic               r_in_box_d1, r_disp_d1;
  logic [3:0]         r_level_d1;
  logic               r_in_box_d2, r_disp_d2;
  logic [3:0]         r_level_d2;
  logic               w_opaque;

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] l);
    logic [7:0] p;
    p = 8'(c) * 8'({1'b0, l} + 5'd1);
    return 4'(p >> 4);
  endfunction

  assign w_step = i_frame_start && (r_cnt == CNT_W'(FRAMES_PER_STEP - 1));
  assign o_busy = (r_state == FADE_IN) || (r_state == FADE_OUT);

  // FSM state, level, step counter, active image and frame-latched position
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_level <= '0;
      r_cnt   <= '0;
      r_num   <= '0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      r_state <= w_state_n;
      r_level <= w_level_n;
      r_cnt   <= w_cnt_n;
      r_num   <= w_num_n;
      if (i_frame_start) begin
        r_pos_x <= i_pos_x;
        r_pos_y <= i_pos_y;
      end
    end
  end

  // Next-state: everything moves only on frame start; IDLE exits at once
  always_comb begin
    w_state_n = r_state;
    w_level_n = r_level;
    w_cnt_n   = r_cnt;
    w_num_n   = r_num;
    if (i_frame_start) begin
      w_cnt_n = w_step ? '0 : r_cnt + 1'b1;
    end
    case (r_state)
      IDLE: begin
        w_level_n = '0;
        w_cnt_n   = '0;
        if (i_frame_start && i_show) begin
          w_num_n   = i_banner_num;
          w_level_n = 4'd1;
          w_state_n = FADE_IN;
        end
      end
      FADE_IN: begin
        if (i_frame_start && !i_show) begin
          w_state_n = FADE_OUT;
          w_cnt_n   = '0;
        end else if (w_step) begin
          w_level_n = r_level + 4'd1;
          if (r_level == 4'd14) begin
            w_state_n = SHOW;
          end
        end
      end
      SHOW: begin
        w_level_n = 4'd15;
        if (i_frame_start && (!i_show || (i_banner_num != r_num))) begin
          w_state_n = FADE_OUT;
          w_cnt_n   = '0;
        end
      end
      FADE_OUT: begin
        if (w_step) begin
          if (r_level <= 4'd1) begin
            w_level_n = '0;
            if (i_show) begin
              w_num_n   = i_banner_num;
              w_state_n = FADE_IN;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_level_n = r_level - 4'd1;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
        w_level_n = '0;
        w_cnt_n   = '0;
      end
    endcase
  end

`ifdef BANNER_FADER_BLINK_EN
  logic [4:0] r_blink;

  // Blink frame counter: runs only while SHOW persists, cleared on leaving it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink <= '0;
    end else if (w_state_n != SHOW) begin
      r_blink <= '0;
    end else if (i_frame_start && (r_state == SHOW)) begin
      r_blink <= r_blink + 5'd1;
    end
  end

  assign w_level_eff = ((r_state == SHOW) && r_blink[4]) ? 4'd0 : r_level;
`else
  assign w_level_eff = r_level;
`endif

  // Geometry: unsigned 12-bit differences so left/above the box wraps large
  assign w_rel_x     = {1'b0, i_h_coord} - {1'b0, r_pos_x};
  assign w_rel_y     = {2'b0, i_v_coord} - {2'b0, r_pos_y};
  assign w_on_screen = (i_h_coord < 11'(SCREEN_WIDTH)) && (i_v_coord < 10'(SCREEN_HEIGHT));
  assign w_in_box    = w_on_screen && (w_rel_x < 12'(BANNER_W)) && (w_rel_y < 12'(BANNER_H));
  assign w_lin       = ADDR_W'(w_rel_y) * ADDR_W'(BANNER_W) + ADDR_W'(w_rel_x);
  assign w_addr      = w_in_box ? w_lin : '0;

  // Stage 1: ROM address/select plus sideband; stage 1b keeps sideband aligned with ROM data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bf.o_rom_addr <= '0;
      bf.o_rom_sel  <= '0;
      r_in_box_d1   <= 1'b0;
      r_disp_d1     <= 1'b0;
      r_level_d1    <= '0;
      r_in_box_d2   <= 1'b0;
      r_disp_d2     <= 1'b0;
      r_level_d2    <= '0;
    end else begin
      bf.o_rom_addr <= w_addr;
      bf.o_rom_sel  <= r_num;
      r_in_box_d1   <= w_in_box;
      r_disp_d1     <= i_disp_enbl;
      r_level_d1    <= w_level_eff;
      r_in_box_d2   <= r_in_box_d1;
      r_disp_d2     <= r_disp_d1;
      r_level_d2    <= r_level_d1;
    end
  end

  assign w_opaque = r_disp_d2 && r_in_box_d2 && (r_level_d2 != 4'd0) && (bf.i_rom_data != 12'h000);

  // Stage 2: brightness-scaled overlay pixel; transparent/outside gives black, not valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bf.o_red       <= '0;
      bf.o_green     <= '0;
      bf.o_blue      <= '0;
      bf.o_pix_valid <= 1'b0;
    end else if (w_opaque) begin
      bf.o_red       <= scale(bf.i_rom_data[3:0],  r_level_d2);
      bf.o_green     <= scale(bf.i_rom_data[7:4],  r_level_d2);
      bf.o_blue      <= scale(bf.i_rom_data[11:8], r_level_d2);
      bf.o_pix_valid <= 1'b1;
    end else begin
      bf.o_red       <= '0;
      bf.o_green     <= '0;
      bf.o_blue      <= '0;
      bf.o_pix_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banner_fader.sv
// Directed bench for banner_fader (FRAMES_PER_STEP=1). Pixel requests push
// their expected ROM address/select and overlay pixel into queues; a
// negedge checker pops them when they fall due.
module tb_banner_fader;
  localparam int BW = 100;
  localparam int BH = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        show;
  logic [1:0]  banner_num;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic        frame_start;
  logic        disp;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        busy;

  banner_fader_if #(.ADDR_W(13), .SEL_W(2)) bf_if ();

  banner_fader #(
    .SCREEN_WIDTH(800), .SCREEN_HEIGHT(600), .BANNER_W(BW), .BANNER_H(BH),
    .NUM_IMAGES(4), .FRAMES_PER_STEP(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_show(show), .i_banner_num(banner_num),
    .i_pos_x(pos_x), .i_pos_y(pos_y), .i_frame_start(frame_start),
    .i_disp_enbl(disp), .i_h_coord(h_coord), .i_v_coord(v_coord),
    .bf(bf_if), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [11:0] rom_const;
  int          m_level;
  logic [10:0] m_px;
  logic [9:0]  m_py;
  logic [1:0]  m_sel;

  typedef struct { int due; logic [12:0] addr; logic [1:0] sel; } a_t;
  typedef struct { int due; logic [12:0] pix; } p_t;
  a_t qa[$];
  p_t qp[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous one-cycle ROM; every address of every image holds rom_const
  always @(posedge clk) bf_if.i_rom_data <= rom_const;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checker: compare queued expectations when they fall due
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      a_t a;
      a = qa.pop_front();
      check("rom_addr", 32'(bf_if.o_rom_addr), 32'(a.addr));
      check("rom_sel", 32'(bf_if.o_rom_sel), 32'(a.sel));
    end
    while (qp.size() > 0 && qp[0].due <= cyc) begin
      p_t p;
      p = qp.pop_front();
      check("pixel", 32'({bf_if.o_pix_valid, bf_if.o_blue, bf_if.o_green, bf_if.o_red}), 32'(p.pix));
    end
  end

  function automatic logic [3:0] sc(input logic [3:0] c);
    int v;
    v = (int'(c) * (m_level + 1)) / 16;
    return 4'(v);
  endfunction

  task automatic pix(input int x, input int y, input logic d);
    logic [11:0] rx, ry;
    logic        ib;
    logic [12:0] ex_addr, ex_pix;
    h_coord = 11'(x);
    v_coord = 10'(y);
    disp    = d;
    rx = 12'(x) - {1'b0, m_px};
    ry = 12'(y) - {2'b0, m_py};
    ib = (rx < 12'(BW)) && (ry < 12'(BH));
    ex_addr = ib ? 13'(int'(ry) * BW + int'(rx)) : 13'd0;
    if (!d || !ib || m_level == 0 || rom_const == 12'h000)
      ex_pix = 13'd0;
    else
      ex_pix = {1'b1, sc(rom_const[11:8]), sc(rom_const[7:4]), sc(rom_const[3:0])};
    qa.push_back('{cyc + 1, ex_addr, m_sel});
    qp.push_back('{cyc + 3, ex_pix});
    @(negedge clk);
  endtask

  task automatic frame();
    disp        = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    m_px = pos_x;
    m_py = pos_y;
  endtask

  task automatic set_rom(input logic [11:0] v);
    disp = 1'b0;
    repeat (4) @(negedge clk);
    rom_const = v;
  endtask

  initial begin
    rst_n = 1'b0; show = 1'b0; banner_num = 2'd0; pos_x = '0; pos_y = '0;
    frame_start = 1'b0; disp = 1'b0; h_coord = '0; v_coord = '0;
    rom_const = 12'hFFF; m_level = 0; m_px = '0; m_py = '0; m_sel = 2'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_pix", 32'({bf_if.o_pix_valid, bf_if.o_blue, bf_if.o_green, bf_if.o_red}), 32'd0);
    check("rst_addr", 32'(bf_if.o_rom_addr), 32'd0);
    check("rst_sel", 32'(bf_if.o_rom_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    pix(360, 280, 1'b1);
    check("idle_busy", 32'(busy), 32'd0);

    // Fade in: level k after k frame starts, SHOW after 15
    pos_x = 11'd350; pos_y = 10'd275; show = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      frame();
      m_level = k;
      check("fadein_busy", 32'(busy), (k < 15) ? 32'd1 : 32'd0);
      pix(360, 280, 1'b1);
    end

    // SHOW: colour decode, box edges, addressing
    set_rom(12'hF84);
    pix(350, 275, 1'b1);
    pix(349, 275, 1'b1);
    pix(449, 324, 1'b1);
    pix(450, 324, 1'b1);
    pix(449, 325, 1'b1);
    pix(350, 274, 1'b1);
    pix(400, 300, 1'b0);
    pix(0, 0, 1'b1);
    set_rom(12'h000);
    pix(360, 280, 1'b1);

    // Position change takes effect only at the next frame start
    set_rom(12'hFFF);
    pos_x = 11'd500;
    pix(350, 275, 1'b1);
    pix(360, 276, 1'b1);
    frame();
    pix(350, 275, 1'b1);
    pix(500, 275, 1'b1);
    check("show_busy", 32'(busy), 32'd0);

    // Image change: fade out on image 0, then fade in on image 2
    banner_num = 2'd2;
    for (int j = 1; j <= 15; j++) begin
      frame();
      m_level = (j == 1) ? 15 : 16 - j;
      check("fadeout_busy", 32'(busy), 32'd1);
      pix(510, 280, 1'b1);
    end
    frame();
    m_level = 0;
    m_sel = 2'd2;
    pix(510, 280, 1'b1);
    check("refade_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      frame();
      m_level = k;
      pix(510, 280, 1'b1);
    end

    // Reset mid-fade blanks the output immediately
    pix(520, 290, 1'b1);
    pix(520, 290, 1'b1);
    @(negedge clk);
    check("pre_rst_valid", 32'(bf_if.o_pix_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pix", 32'({bf_if.o_pix_valid, bf_if.o_blue, bf_if.o_green, bf_if.o_red}), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_addr", 32'(bf_if.o_rom_addr), 32'd0);
    qa.delete();
    qp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    m_level = 0; m_px = '0; m_py = '0; m_sel = 2'd0;
    pix(20, 20, 1'b1);
    check("post_rst_busy", 32'(busy), 32'd0);
    show = 1'b0;
    frame();
    check("idle_noshow_busy", 32'(busy), 32'd0);
    pix(520, 290, 1'b1);
    show = 1'b1;
    banner_num = 2'd1;
    frame();
    m_level = 1;
    m_sel = 2'd1;
    check("restart_busy", 32'(busy), 32'd1);
    pix(520, 290, 1'b1);

    // Show dropped during fade-in: fade out from current level, then idle
    frame();
    m_level = 2;
    pix(520, 290, 1'b1);
    show = 1'b0;
    frame();
    check("abort_busy", 32'(busy), 32'd1);
    pix(520, 290, 1'b1);
    frame();
    m_level = 1;
    pix(520, 290, 1'b1);
    frame();
    m_level = 0;
    check("end_idle_busy", 32'(busy), 32'd0);
    pix(520, 290, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(qa.size() + qp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
